multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Moore-style sequencer that drives a shared-ALU, single-memory multi-cycle datapath for the mini-cpu subset: add, sub, and, or, ld, sd, beq.
- Replaces per-instruction combinational control with a state machine that steps each instruction through fetch, decode, execute, memory and writeback.
- Handshakes with instruction/data memory through a ready signal.
- A watchdog traps memory accesses that never complete.

Parameters:
- TIMEOUT, 15: maximum cycles a memory access may wait for mem_ready; 0 disables the watchdog.
- TIMEOUT_W, 4: width of the wait counter; must satisfy TIMEOUT < 2**TIMEOUT_W.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- instr  input  32  instruction register contents; valid from the DECODE state onward.
- zero  input  1  ALU zero flag (rs1 == rs2 during BRANCH).
- mem_ready  input  1  memory completed the current access this cycle.
- ir_write  output  1  load instruction register from memory read data.
- pc_write  output  1  PC <= PC+4; datapath latches old_pc at the same time.
- branch_taken  output  1  PC <= old_pc + imm.
- mem_read  output  1  memory read request; held until mem_ready.
- mem_write  output  1  memory write request; held until mem_ready.
- i_or_d  output  1  memory address source: 0 = PC, 1 = ALU result register.
- reg_write  output  1  register file write enable.
- mem_to_reg  output  1  writeback source: 0 = ALU result, 1 = memory data register.
- alu_src  output  1  ALU B operand: 0 = rs2, 1 = immediate.
- alu_ctrl  output  3  ALU op: 010 add, 110 sub, 000 and, 001 or.
- illegal  output  1  sticky; an unsupported encoding was decoded.
- timeout  output  1  sticky; a memory access exceeded TIMEOUT cycles.

Behaviour:
- States: FETCH, DECODE, EXEC_R, WB_R, MEM_ADDR, MEM_RD, WB_LD, MEM_WR, BRANCH, HALT.
- Reset: state = FETCH, wait counter = 0, illegal = 0, timeout = 0.
  - All outputs read 0 except mem_read = 1 and i_or_d = 0, which are the FETCH outputs.
  - alu_ctrl = 010.
- Output defaults: every output not listed for a state is 0; alu_ctrl defaults to 010.
- FETCH: mem_read = 1, i_or_d = 0.
  - On mem_ready: ir_write = 1 and pc_write = 1 in the same cycle, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: alu_ctrl = 010 (precomputes the branch target). Next state by opcode:
  - 51 -> EXEC_R.
  - 3 or 35 -> MEM_ADDR.
  - 99 -> BRANCH.
  - Any other opcode -> HALT, setting illegal.
- R-type decoding (checked in DECODE):
  - funct3 0, funct7 0 -> add (010).
  - funct3 0, funct7 32 -> sub (110).
  - funct3 6, funct7 0 -> and (000).
  - funct3 7, funct7 0 -> or (001).
  - Any other funct3/funct7 combination -> HALT with illegal set.
- EXEC_R: alu_src = 0, alu_ctrl = the decoded op; go to WB_R.
- WB_R: reg_write = 1, mem_to_reg = 0; go to FETCH.
- MEM_ADDR: alu_src = 1, alu_ctrl = 010. Go to MEM_RD when opcode = 3, MEM_WR when opcode = 35.
- MEM_RD: mem_read = 1, i_or_d = 1; on mem_ready go to WB_LD.
- WB_LD: reg_write = 1, mem_to_reg = 1; go to FETCH.
- MEM_WR: mem_write = 1, i_or_d = 1; on mem_ready go to FETCH.
- BRANCH: alu_src = 0, alu_ctrl = 110, branch_taken = zero; go to FETCH.
- HALT: absorbing state, all outputs 0; only rst exits it.
- Latency with zero wait states (mem_ready high on the first request cycle):
  - R-type 4 cycles, ld 5, sd 4, beq 3.
  - Each extra wait cycle adds 1.
- Watchdog:
  - The counter clears on entry to FETCH, MEM_RD and MEM_WR, and increments on each cycle in those states with mem_ready = 0.
  - When the counter reaches TIMEOUT while still waiting: go to HALT and set timeout.
  - mem_ready arriving in the same cycle the counter reaches TIMEOUT counts as success.
  - The counter saturates and never wraps.
- mem_read and mem_write are never high together.
- reg_write, pc_write, mem_write and ir_write are never high after HALT is entered.
- Asynchronous reset mid-access drops mem_read/mem_write immediately; any in-flight memory response is ignored.
- instr is sampled combinationally in DECODE through the last instruction state; it must stay stable until the return to FETCH.

Decomposition:
- Package mini_cpu_pkg:
  - Opcode constants (51, 3, 35, 99).
  - funct3/funct7 constants.
  - alu_ctrl encodings as an enum.
  - State enum.
- One combinational sub-module, mc_decode: instr -> instruction class (R, LD, SD, BEQ, ILLEGAL) plus the R-type alu_ctrl.

Test Plan:
1. Reset, then add x3,x1,x2 (0x002081B3) with mem_ready always 1 -> FETCH, DECODE, EXEC_R, WB_R; alu_ctrl 010; reg_write=1 only in cycle 4; pc_write=1 only in cycle 1.
2. sub (funct7=32) and or (funct3=7) -> alu_ctrl 110 and 001 in EXEC_R. and with funct7=1 -> HALT, illegal=1, no reg_write.
3. ld with mem_ready low for 3 cycles in MEM_RD -> mem_read and i_or_d held high 4 cycles; WB_LD asserts reg_write=1, mem_to_reg=1; total 8 cycles.
4. beq with zero=1, then with zero=0 -> branch_taken=1 / 0 in cycle 3; alu_ctrl 110; next cycle is FETCH.
5. sd with mem_ready held 0 and TIMEOUT=15 -> HALT after 15 wait cycles, timeout=1, mem_write=0 from then on. Repeat with mem_ready rising exactly on cycle 15 -> no timeout.
6. Assert rst mid-MEM_WR -> mem_write drops asynchronously. After release: state FETCH, illegal=0, timeout=0.

Source files
------------

// File: rtl/mini_cpu_pkg.sv
// Shared encodings for the mini-cpu multi-cycle controller: opcodes, function
// fields, ALU control codes, instruction classes and sequencer states.
package mini_cpu_pkg;

  localparam logic [6:0] OP_R   = 7'd51;
  localparam logic [6:0] OP_LD  = 7'd3;
  localparam logic [6:0] OP_SD  = 7'd35;
  localparam logic [6:0] OP_BEQ = 7'd99;

  localparam logic [2:0] F3_ADD_SUB = 3'd0;
  localparam logic [2:0] F3_AND     = 3'd6;
  localparam logic [2:0] F3_OR      = 3'd7;

  localparam logic [6:0] F7_BASE = 7'd0;
  localparam logic [6:0] F7_SUB  = 7'd32;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110
  } alu_ctrl_e;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_LD,
    CLS_SD,
    CLS_BEQ,
    CLS_ILLEGAL
  } instr_class_e;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_WB_R,
    S_MEM_ADDR,
    S_MEM_RD,
    S_WB_LD,
    S_MEM_WR,
    S_BRANCH,
    S_HALT
  } state_e;

  function automatic logic is_mem_state(state_e s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier; also resolves the R-type ALU op so the
// sequencer only has to forward it during EXEC_R.
module mc_decode
  import mini_cpu_pkg::*;
(
  input  logic [31:0]  instr,
  output instr_class_e instr_class,
  output alu_ctrl_e    r_alu_ctrl
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  always_comb begin
    instr_class = CLS_ILLEGAL;
    r_alu_ctrl  = ALU_ADD;
    case (opcode)
      OP_R: begin
        instr_class = CLS_R;
        if (funct3 == F3_ADD_SUB && funct7 == F7_BASE) begin
          r_alu_ctrl = ALU_ADD;
        end else if (funct3 == F3_ADD_SUB && funct7 == F7_SUB) begin
          r_alu_ctrl = ALU_SUB;
        end else if (funct3 == F3_AND && funct7 == F7_BASE) begin
          r_alu_ctrl = ALU_AND;
        end else if (funct3 == F3_OR && funct7 == F7_BASE) begin
          r_alu_ctrl = ALU_OR;
        end else begin
          instr_class = CLS_ILLEGAL;
        end
      end
      OP_LD:   instr_class = CLS_LD;
      OP_SD:   instr_class = CLS_SD;
      OP_BEQ:  instr_class = CLS_BEQ;
      default: instr_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore sequencer for the shared-ALU, single-memory mini-cpu datapath, with a
// watchdog that halts the core when a memory access never completes.
//
// state      | meaning
// FETCH      | read instruction at PC; on ready load IR and bump PC
// DECODE     | classify instr, ALU precomputes branch target
// EXEC_R     | ALU computes rs1 op rs2
// WB_R       | write ALU result to rd
// MEM_ADDR   | ALU computes rs1 + imm
// MEM_RD     | data read at ALU result, wait for ready
// WB_LD      | write memory data to rd
// MEM_WR     | data write at ALU result, wait for ready
// BRANCH     | compare rs1/rs2, redirect PC when equal
// HALT       | trapped on illegal encoding or timeout; only reset exits
module multicycle_control
  import mini_cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 15,
  parameter int unsigned TIMEOUT_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        ir_write,
  output logic        pc_write,
  output logic        branch_taken,
  output logic        mem_read,
  output logic        mem_write,
  output logic        i_or_d,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        alu_src,
  output logic [2:0]  alu_ctrl,
  output logic        illegal,
  output logic        timeout
);

  localparam bit                   WDOG_EN  = (TIMEOUT != 0);
  localparam logic [TIMEOUT_W-1:0] CNT_MAX  = '1;
  // Expiry is judged on the cycle the counter would step onto TIMEOUT, so a
  // ready arriving in that same cycle still wins.
  localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT - 1);

  state_e               state, state_next;
  logic [TIMEOUT_W-1:0] wait_cnt, wait_cnt_next;
  instr_class_e         instr_class;
  alu_ctrl_e            r_alu_ctrl;
  logic                 waiting;
  logic                 expire;

  mc_decode u_decode (
    .instr       (instr),
    .instr_class (instr_class),
    .r_alu_ctrl  (r_alu_ctrl)
  );

  assign waiting = is_mem_state(state) && !mem_ready;
  assign expire  = WDOG_EN && waiting && (wait_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      illegal  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (state == S_DECODE && state_next == S_HALT) illegal <= 1'b1;
      if (expire) timeout <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH: begin
        if (mem_ready)   state_next = S_DECODE;
        else if (expire) state_next = S_HALT;
      end
      S_DECODE: begin
        case (instr_class)
          CLS_R:          state_next = S_EXEC_R;
          CLS_LD, CLS_SD: state_next = S_MEM_ADDR;
          CLS_BEQ:        state_next = S_BRANCH;
          default:        state_next = S_HALT;
        endcase
      end
      S_EXEC_R: state_next = S_WB_R;
      S_WB_R:   state_next = S_FETCH;
      S_MEM_ADDR: begin
        if (instr_class == CLS_LD)      state_next = S_MEM_RD;
        else if (instr_class == CLS_SD) state_next = S_MEM_WR;
        else                            state_next = S_HALT;
      end
      S_MEM_RD: begin
        if (mem_ready)   state_next = S_WB_LD;
        else if (expire) state_next = S_HALT;
      end
      S_WB_LD: state_next = S_FETCH;
      S_MEM_WR: begin
        if (mem_ready)   state_next = S_FETCH;
        else if (expire) state_next = S_HALT;
      end
      S_BRANCH: state_next = S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_HALT;
    endcase
  end

  always_comb begin
    wait_cnt_next = wait_cnt;
    if (state_next != state && is_mem_state(state_next)) begin
      wait_cnt_next = '0;
    end else if (waiting && wait_cnt != CNT_MAX) begin
      wait_cnt_next = wait_cnt + 1'b1;
    end
  end

  always_comb begin
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    branch_taken = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    i_or_d       = 1'b0;
    reg_write    = 1'b0;
    mem_to_reg   = 1'b0;
    alu_src      = 1'b0;
    alu_ctrl     = ALU_ADD;
    case (state)
      S_FETCH: begin
        mem_read = 1'b1;
        // A response seen while reset is held belongs to an aborted access.
        ir_write = mem_ready && !rst;
        pc_write = mem_ready && !rst;
      end
      S_EXEC_R: begin
        alu_src  = 1'b0;
        alu_ctrl = r_alu_ctrl;
      end
      S_WB_R: reg_write = 1'b1;
      S_MEM_ADDR: alu_src = 1'b1;
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_WB_LD: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_BRANCH: begin
        alu_ctrl     = ALU_SUB;
        branch_taken = zero;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed per-cycle vector bench for multicycle_control, plus a hand-driven
// asynchronous-reset-during-store sequence.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        ir_write, pc_write, branch_taken, mem_read, mem_write, i_or_d;
  logic        reg_write, mem_to_reg, alu_src, illegal, timeout;
  logic [2:0]  alu_ctrl;
  logic [13:0] outs;

  always #5 clk = ~clk;

  multicycle_control #(.TIMEOUT(15), .TIMEOUT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr        (instr),
    .zero         (zero),
    .mem_ready    (mem_ready),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .branch_taken (branch_taken),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .i_or_d       (i_or_d),
    .reg_write    (reg_write),
    .mem_to_reg   (mem_to_reg),
    .alu_src      (alu_src),
    .alu_ctrl     (alu_ctrl),
    .illegal      (illegal),
    .timeout      (timeout)
  );

  assign outs = {ir_write, pc_write, branch_taken, mem_read, mem_write, i_or_d,
                 reg_write, mem_to_reg, alu_src, alu_ctrl, illegal, timeout};

  typedef struct {
    logic        rst;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic [13:0] exp;
    int          test;
  } vec_t;

  vec_t vecs[$];
  int   applied = 0;
  int   miscompares = 0;

  localparam logic [2:0] A_ADD = 3'b010;
  localparam logic [2:0] A_SUB = 3'b110;
  localparam logic [2:0] A_AND = 3'b000;
  localparam logic [2:0] A_OR  = 3'b001;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_OR   = 32'h0020F1B3;
  localparam logic [31:0] I_BADA = 32'h0220E1B3;
  localparam logic [31:0] I_ADDI = 32'h00000013;
  localparam logic [31:0] I_LD   = 32'h0080B283;
  localparam logic [31:0] I_SD   = 32'h0020B423;
  localparam logic [31:0] I_BEQ  = 32'h00208063;

  // Field order: ir pc bt mr mw iod rw m2r asrc alu ill to
  function automatic logic [13:0] mk(bit irw, bit pcw, bit bt, bit mr, bit mw,
                                     bit iod, bit rw, bit m2r, bit asrc,
                                     logic [2:0] alu, bit ill, bit to);
    return {irw, pcw, bt, mr, mw, iod, rw, m2r, asrc, alu, ill, to};
  endfunction

  logic [13:0] f_wait, f_rdy, dec, wbr, maddr, mrd, wbld, mwr;

  task automatic add(input logic r, input logic [31:0] i, input logic z,
                     input logic rdy, input logic [13:0] e, input int t);
    vec_t v;
    v.rst = r; v.instr = i; v.zero = z; v.mem_ready = rdy; v.exp = e; v.test = t;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [13:0] got, input logic [13:0] want);
    applied++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: outputs %b, expected %b", name, got, want);
    end
  endtask

  task automatic add_rtype(input logic [31:0] i, input logic [2:0] op, input int t);
    add(0, i, 0, 1, f_rdy, t);
    add(0, i, 0, 1, dec, t);
    add(0, i, 0, 1, mk(0,0,0,0,0,0,0,0,0,op,0,0), t);
    add(0, i, 0, 1, wbr, t);
  endtask

  initial begin
    rst = 1'b0; instr = '0; zero = 1'b0; mem_ready = 1'b0;
    #1 rst = 1'b1;

    f_wait = mk(0,0,0,1,0,0,0,0,0,A_ADD,0,0);
    f_rdy  = mk(1,1,0,1,0,0,0,0,0,A_ADD,0,0);
    dec    = mk(0,0,0,0,0,0,0,0,0,A_ADD,0,0);
    wbr    = mk(0,0,0,0,0,0,1,0,0,A_ADD,0,0);
    maddr  = mk(0,0,0,0,0,0,0,0,1,A_ADD,0,0);
    mrd    = mk(0,0,0,1,0,1,0,0,0,A_ADD,0,0);
    wbld   = mk(0,0,0,0,0,0,1,1,0,A_ADD,0,0);
    mwr    = mk(0,0,0,0,1,1,0,0,0,A_ADD,0,0);

    // Reset holds FETCH outputs; a ready during reset must not load IR.
    add(1, 0, 0, 1, f_wait, 1);
    add(1, 0, 0, 0, f_wait, 1);
    add_rtype(I_ADD, A_ADD, 1);
    add_rtype(I_SUB, A_SUB, 2);
    add(0, I_OR, 0, 0, f_wait, 2);
    add(0, I_OR, 0, 0, f_wait, 2);
    add_rtype(I_OR, A_OR, 2);
    // ld with three wait states in MEM_RD
    add(0, I_LD, 0, 1, f_rdy, 3);
    add(0, I_LD, 0, 1, dec, 3);
    add(0, I_LD, 0, 1, maddr, 3);
    for (int k = 0; k < 3; k++) add(0, I_LD, 0, 0, mrd, 3);
    add(0, I_LD, 0, 1, mrd, 3);
    add(0, I_LD, 0, 1, wbld, 3);
    // beq taken then not taken
    add(0, I_BEQ, 1, 1, f_rdy, 4);
    add(0, I_BEQ, 1, 1, dec, 4);
    add(0, I_BEQ, 1, 1, mk(0,0,1,0,0,0,0,0,0,A_SUB,0,0), 4);
    add(0, I_BEQ, 0, 1, f_rdy, 4);
    add(0, I_BEQ, 0, 1, dec, 4);
    add(0, I_BEQ, 0, 1, mk(0,0,0,0,0,0,0,0,0,A_SUB,0,0), 4);
    // sd whose ready lands on the last permitted wait cycle
    add(0, I_SD, 0, 1, f_rdy, 5);
    add(0, I_SD, 0, 1, dec, 5);
    add(0, I_SD, 0, 1, maddr, 5);
    for (int k = 0; k < 14; k++) add(0, I_SD, 0, 0, mwr, 5);
    add(0, I_SD, 0, 1, mwr, 5);
    // and with funct7=1 is illegal; HALT absorbs even with ready high
    add(0, I_BADA, 0, 1, f_rdy, 2);
    add(0, I_BADA, 0, 1, dec, 2);
    add(0, I_BADA, 0, 1, mk(0,0,0,0,0,0,0,0,0,A_ADD,1,0), 2);
    add(0, I_BADA, 0, 1, mk(0,0,0,0,0,0,0,0,0,A_ADD,1,0), 2);
    add(1, 0, 0, 0, f_wait, 6);
    add(0, I_ADDI, 0, 1, f_rdy, 2);
    add(0, I_ADDI, 0, 1, dec, 2);
    add(0, I_ADDI, 0, 1, mk(0,0,0,0,0,0,0,0,0,A_ADD,1,0), 2);
    add(1, 0, 0, 0, f_wait, 6);
    // sd that never completes -> watchdog
    add(0, I_SD, 0, 1, f_rdy, 5);
    add(0, I_SD, 0, 1, dec, 5);
    add(0, I_SD, 0, 1, maddr, 5);
    for (int k = 0; k < 15; k++) add(0, I_SD, 0, 0, mwr, 5);
    add(0, I_SD, 0, 0, mk(0,0,0,0,0,0,0,0,0,A_ADD,0,1), 5);
    add(0, I_SD, 0, 1, mk(0,0,0,0,0,0,0,0,0,A_ADD,0,1), 5);
    add(1, 0, 0, 0, f_wait, 6);
    add(0, I_ADD, 0, 1, f_rdy, 6);
    add(0, I_ADD, 0, 1, dec, 6);

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      rst       = vecs[k].rst;
      instr     = vecs[k].instr;
      zero      = vecs[k].zero;
      mem_ready = vecs[k].mem_ready;
      #2;
      check($sformatf("vec %0d (test %0d)", k, vecs[k].test), outs, vecs[k].exp);
    end

    // Asynchronous reset in the middle of a store wait
    @(negedge clk); rst = 1'b1; mem_ready = 1'b0;
    @(negedge clk); rst = 1'b0; instr = I_SD; mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk); mem_ready = 1'b0;
    @(negedge clk); #1;
    check("mem_wr entered", outs, mwr);
    @(posedge clk); #2;
    check("mem_wr waiting", outs, mwr);
    mem_ready = 1'b1;
    rst = 1'b1;
    #1;
    check("async rst drops mem_write", outs, f_wait);
    @(negedge clk); rst = 1'b0; mem_ready = 1'b0; #2;
    check("post-reset fetch", outs, f_wait);
    @(posedge clk); #1;
    check("fetch holds without ready", outs, f_wait);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
